// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader_pkg
//  Description : Definitions shared by the UART loader, the CPU and uart_rx.
//                Contains the FSM state encodings, the 8N1 frame constants
//                and the default baud constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

  // Frame FSM of the loader: one state per field of the frame.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } loader_state_t;

  // Bit-level FSM of the 8N1 receiver.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // 8N1 framing: 8 data bits between one start bit and one stop bit.
  localparam int c_uart_data_bits = 8;

  // 10 MHz clock at 19200 baud.
  localparam int c_default_baud_counts = 521;
  localparam int c_default_baud_bits   = 10;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, LSB first, idle-high line. Bits are
//                sampled in the middle of each bit period. A byte is only
//                reported when its stop bit reads high.
//  Ports       : clk_i    - clock
//                reset_i  - asynchronous active-low reset
//                rx_i     - serial line (asynchronous to clk_i)
//                data_o   - last received byte
//                valid_o  - one-cycle strobe, data_o valid in that cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int BAUD_COUNTS_PER_BIT        = c_default_baud_counts,
  parameter int BAUD_RATE_COUNTER_BITWIDTH = c_default_baud_bits
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] c_half =
    BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT / 2 - 1);
  localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] c_full =
    BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT - 1);
  localparam logic [2:0] c_last_bit = 3'(c_uart_data_bits - 1);

  rx_state_t                             r_state;
  rx_state_t                             w_state_next;
  logic [1:0]                            r_sync;
  logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] r_cnt;
  logic [2:0]                            r_bit_idx;
  logic [7:0]                            r_shift;
  logic [7:0]                            r_data;
  logic                                  r_valid;
  logic                                  w_rx;
  logic                                  w_half_hit;
  logic                                  w_full_hit;

  assign w_rx       = r_sync[1];
  assign w_half_hit = (r_cnt == c_half);
  assign w_full_hit = (r_cnt == c_full);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= RX_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RX_IDLE:  if (!w_rx) w_state_next = RX_START;
      // A start bit that is high again at mid-bit was a glitch.
      RX_START: if (w_half_hit) w_state_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full_hit && (r_bit_idx == c_last_bit)) w_state_next = RX_STOP;
      RX_STOP:  if (w_full_hit) w_state_next = RX_IDLE;
      default:  w_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx_i};
      r_valid <= 1'b0;
      case (r_state)
        RX_START: r_cnt <= w_half_hit ? '0 : r_cnt + 1'b1;
        RX_DATA: begin
          if (w_full_hit) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_full_hit) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
        end
      endcase
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;

endmodule
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader
//  Description : Receives a framed image (ADDR, LEN, LEN payload bytes, CSUM)
//                over UART and writes it into memory as DATA_WIDTH-bit words,
//                MSB word first, starting at ADDR and wrapping modulo DEPTH.
//                Checks length, checksum and inter-byte timeout.
//  Ports       : clk_i        - clock
//                reset_i      - asynchronous active-low reset
//                p_programm_i - programming enable, a rising edge starts a frame
//                rx_i         - UART line, 8N1
//                wr_en_o      - one-cycle write strobe per word
//                wr_addr_o    - write address (held between strobes)
//                wr_data_o    - write data (held between strobes)
//                busy_o       - high whenever a frame is in progress
//                done_o       - frame accepted with a good checksum
//                error_o      - sticky frame error
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int DATA_WIDTH                 = 4,
  parameter int ADDR_WIDTH                 = 4,
  parameter int BAUD_COUNTS_PER_BIT        = c_default_baud_counts,
  parameter int BAUD_RATE_COUNTER_BITWIDTH = c_default_baud_bits,
  parameter int TIMEOUT_CYCLES             = 65535,
  parameter int TIMEOUT_WIDTH              = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  p_programm_i,
  input  logic                  rx_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int         c_wpb       = 8 / DATA_WIDTH;
  localparam int         c_depth     = 2 ** ADDR_WIDTH;
  localparam logic [8:0] c_max_len   = 9'(c_depth / c_wpb);
  localparam logic [3:0] c_burst_rem = 4'(c_wpb - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] c_timeout = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  loader_state_t           r_state;
  loader_state_t           w_state_next;
  logic                    r_prog_d;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [7:0]              r_len_left;
  logic [7:0]              r_csum;
  logic [7:0]              r_shift;
  logic [3:0]              r_burst_left;
  logic                    r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic                    r_done;
  logic                    r_error;
  logic [TIMEOUT_WIDTH-1:0] r_timeout;

  logic [7:0] w_rx_data;
  logic       w_rx_valid;
  logic       w_burst_busy;
  logic       w_timeout;
  logic       w_len_bad;
  logic       w_start;
  logic       w_take_byte;
  logic       w_set_done;
  logic       w_set_error;

  uart_rx #(
    .BAUD_COUNTS_PER_BIT       (BAUD_COUNTS_PER_BIT),
    .BAUD_RATE_COUNTER_BITWIDTH(BAUD_RATE_COUNTER_BITWIDTH)
  ) u_rx (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .rx_i   (rx_i),
    .data_o (w_rx_data),
    .valid_o(w_rx_valid)
  );

  assign w_burst_busy = (r_burst_left != 4'd0);
  assign w_timeout    = (r_timeout == c_timeout);
  assign w_len_bad    = (w_rx_data == 8'd0) || ({1'b0, w_rx_data} > c_max_len);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_take_byte  = 1'b0;
    w_set_done   = 1'b0;
    w_set_error  = 1'b0;
    if (r_state == ST_IDLE) begin
      if (p_programm_i && !r_prog_d) begin
        w_start      = 1'b1;
        w_state_next = ST_ADDR;
      end
    end else if (!p_programm_i) begin
      // Let an ongoing word burst finish before leaving the frame.
      if (!w_burst_busy) begin
        w_set_error  = 1'b1;
        w_state_next = ST_IDLE;
      end
    end else if (w_timeout) begin
      w_set_error  = 1'b1;
      w_state_next = ST_IDLE;
    end else if (w_rx_valid) begin
      w_take_byte = 1'b1;
      case (r_state)
        ST_ADDR: w_state_next = ST_LEN;
        ST_LEN: begin
          if (w_len_bad) begin
            w_set_error  = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_DATA;
          end
        end
        ST_DATA: if (r_len_left == 8'd1) w_state_next = ST_CSUM;
        ST_CSUM: begin
          w_set_done   = (w_rx_data == r_csum);
          w_set_error  = (w_rx_data != r_csum);
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_prog_d     <= 1'b0;
      r_ptr        <= '0;
      r_len_left   <= '0;
      r_csum       <= '0;
      r_shift      <= '0;
      r_burst_left <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_timeout    <= '0;
    end else begin
      r_prog_d <= p_programm_i;
      r_wr_en  <= 1'b0;

      if (w_start) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
        r_csum  <= '0;
      end
      if (w_set_done)  r_done  <= 1'b1;
      if (w_set_error) r_error <= 1'b1;

      if ((r_state == ST_IDLE) || w_rx_valid) r_timeout <= '0;
      else if (!w_timeout)                    r_timeout <= r_timeout + 1'b1;

      if (w_take_byte) begin
        r_csum <= r_csum + w_rx_data;
        if (r_state == ST_ADDR) r_ptr      <= w_rx_data[ADDR_WIDTH-1:0];
        if (r_state == ST_LEN)  r_len_left <= w_rx_data;
        if (r_state == ST_DATA) r_len_left <= r_len_left - 8'd1;
      end

      // The first word goes out straight from the received byte so that its
      // strobe lands in the cycle right after the byte strobe; the remaining
      // words are shifted out of r_shift on the following cycles.
      if (w_take_byte && (r_state == ST_DATA)) begin
        r_wr_en      <= 1'b1;
        r_wr_addr    <= r_ptr;
        r_wr_data    <= w_rx_data[7 -: DATA_WIDTH];
        r_ptr        <= r_ptr + 1'b1;
        r_shift      <= w_rx_data << DATA_WIDTH;
        r_burst_left <= c_burst_rem;
      end else if (w_burst_busy) begin
        r_wr_en      <= 1'b1;
        r_wr_addr    <= r_ptr;
        r_wr_data    <= r_shift[7 -: DATA_WIDTH];
        r_ptr        <= r_ptr + 1'b1;
        r_shift      <= r_shift << DATA_WIDTH;
        r_burst_left <= r_burst_left - 4'd1;
      end
    end
  end

  assign wr_en_o   = r_wr_en;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;
  assign busy_o    = (r_state != ST_IDLE);
  assign done_o    = r_done;
  assign error_o   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_loader
//  Description : Self-checking bench for uart_loader. Table of frames with
//                expected writes and flags, plus hand-written sequences for
//                timeout, abort, asynchronous reset and DATA_WIDTH=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

  localparam int BAUD = 16;
  localparam int TMO  = 400;

  logic clk = 1'b0, reset_n = 1'b1;
  logic prog = 1'b0, rx = 1'b1, prog2 = 1'b0, rx2 = 1'b1;
  logic       wr_en, busy, done, error;
  logic [3:0] wr_addr, wr_data;
  logic       wr_en2, busy2, done2, error2;
  logic [3:0] wr_addr2;
  logic [1:0] wr_data2;

  int checks = 0, failures = 0, both_hi = 0;
  logic [7:0] wq[$];
  logic [5:0] wq2[$];

  typedef struct {
    int              nb;
    logic [11:0][7:0] b;
    int              nw;
    logic [15:0][7:0] w;   // {addr, data}
    logic            done;
    logic            err;
  } vec_t;
  vec_t vecs[6];

  uart_loader #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .BAUD_COUNTS_PER_BIT(BAUD),
                .BAUD_RATE_COUNTER_BITWIDTH(5), .TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(16))
  u_dut (.clk_i(clk), .reset_i(reset_n), .p_programm_i(prog), .rx_i(rx),
         .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
         .busy_o(busy), .done_o(done), .error_o(error));

  uart_loader #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .BAUD_COUNTS_PER_BIT(BAUD),
                .BAUD_RATE_COUNTER_BITWIDTH(5), .TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(16))
  u_dut2 (.clk_i(clk), .reset_i(reset_n), .p_programm_i(prog2), .rx_i(rx2),
          .wr_en_o(wr_en2), .wr_addr_o(wr_addr2), .wr_data_o(wr_data2),
          .busy_o(busy2), .done_o(done2), .error_o(error2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en)  wq.push_back({wr_addr, wr_data});
    if (wr_en2) wq2.push_back({wr_addr2, wr_data2});
    if ((done && error) || (done2 && error2)) both_hi++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(int which, logic val);
    if (which == 0) rx = val;
    else            rx2 = val;
  endtask

  task automatic send_byte(int which, logic [7:0] x);
    drive(which, 1'b0);
    repeat (BAUD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(which, x[i]);
      repeat (BAUD) @(posedge clk);
    end
    drive(which, 1'b1);
    repeat (BAUD) @(posedge clk);
  endtask

  task automatic start_frame(int which);
    if (which == 0) prog = 1'b0; else prog2 = 1'b0;
    repeat (3) @(posedge clk);
    if (which == 0) prog = 1'b1; else prog2 = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic add_b(int v, logic [7:0] x);
    vecs[v].b[vecs[v].nb] = x;
    vecs[v].nb++;
  endtask

  task automatic add_w(int v, logic [3:0] a, logic [3:0] d);
    vecs[v].w[vecs[v].nw] = {a, d};
    vecs[v].nw++;
  endtask

  task automatic run_vec(int v);
    wq.delete();
    start_frame(0);
    for (int j = 0; j < vecs[v].nb; j++) send_byte(0, vecs[v].b[j]);
    repeat (2 * BAUD) @(posedge clk);
    #1;
    check($sformatf("v%0d wr_count", v), wq.size(), vecs[v].nw);
    for (int j = 0; j < vecs[v].nw; j++)
      if (j < wq.size()) check($sformatf("v%0d wr%0d", v, j), wq[j], vecs[v].w[j]);
    check($sformatf("v%0d done", v), done, vecs[v].done);
    check($sformatf("v%0d error", v), error, vecs[v].err);
    check($sformatf("v%0d busy", v), busy, 0);
  endtask

  initial begin
    for (int v = 0; v < 6; v++) begin
      vecs[v].nb = 0; vecs[v].nw = 0; vecs[v].b = '0; vecs[v].w = '0;
      vecs[v].done = 1'b0; vecs[v].err = 1'b1;
    end
    // good frame at address 0
    add_b(0, 8'h00); add_b(0, 8'h02); add_b(0, 8'hDE); add_b(0, 8'hCF); add_b(0, 8'hAF);
    add_w(0, 4'h0, 4'hD); add_w(0, 4'h1, 4'hE); add_w(0, 4'h2, 4'hC); add_w(0, 4'h3, 4'hF);
    vecs[0].done = 1'b1; vecs[0].err = 1'b0;
    // address wrap E,F,0,1
    add_b(1, 8'h0E); add_b(1, 8'h02); add_b(1, 8'h12); add_b(1, 8'h34); add_b(1, 8'h56);
    add_w(1, 4'hE, 4'h1); add_w(1, 4'hF, 4'h2); add_w(1, 4'h0, 4'h3); add_w(1, 4'h1, 4'h4);
    vecs[1].done = 1'b1; vecs[1].err = 1'b0;
    // bad checksum (correct would be AC), writes stay
    add_b(2, 8'h00); add_b(2, 8'h01); add_b(2, 8'hAB); add_b(2, 8'h00);
    add_w(2, 4'h0, 4'hA); add_w(2, 4'h1, 4'hB);
    // LEN = 0 and LEN = 9 (capacity 8)
    add_b(3, 8'h00); add_b(3, 8'h00);
    add_b(4, 8'h00); add_b(4, 8'h09);
    // LEN = 8 full capacity from address 5: nibbles 0..F, checksum CD
    add_b(5, 8'h05); add_b(5, 8'h08);
    add_b(5, 8'h01); add_b(5, 8'h23); add_b(5, 8'h45); add_b(5, 8'h67);
    add_b(5, 8'h89); add_b(5, 8'hAB); add_b(5, 8'hCD); add_b(5, 8'hEF);
    add_b(5, 8'hCD);
    for (int k = 0; k < 16; k++) add_w(5, 4'(5 + k), 4'(k));
    vecs[5].done = 1'b1; vecs[5].err = 1'b0;

    // reset
    #2 reset_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset outputs dut1", {wr_en, wr_addr, wr_data, busy, done, error}, 0);
    check("reset outputs dut2", {wr_en2, wr_addr2, wr_data2, busy2, done2, error2}, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    for (int v = 0; v < 6; v++) run_vec(v);

    // timeout: no early trip, then trip, then recovery by a good frame
    wq.delete();
    start_frame(0);
    send_byte(0, 8'h00); send_byte(0, 8'h02); send_byte(0, 8'hDE);
    repeat (TMO - 60) @(posedge clk);
    #1;
    check("tmo busy before", busy, 1);
    check("tmo error before", error, 0);
    repeat (100) @(posedge clk);
    #1;
    check("tmo error", error, 1);
    check("tmo busy", busy, 0);
    check("tmo done", done, 0);
    check("tmo wr_count", wq.size(), 2);
    if (wq.size() == 2) begin
      check("tmo wr0", wq[0], 8'h0D);
      check("tmo wr1", wq[1], 8'h1E);
    end
    run_vec(0);

    // abort: p_programm_i dropped after LEN
    wq.delete();
    start_frame(0);
    send_byte(0, 8'h00); send_byte(0, 8'h03);
    #1;
    check("abort busy before", busy, 1);
    check("abort error before", error, 0);
    @(posedge clk);
    prog = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort error", error, 1);
    check("abort busy", busy, 0);
    check("abort wr_count", wq.size(), 0);

    // asynchronous reset in the middle of the payload
    wq.delete();
    start_frame(0);
    send_byte(0, 8'h00); send_byte(0, 8'h04); send_byte(0, 8'h11);
    check("rst wr_count before", wq.size(), 2);
    rx = 1'b0;
    repeat (BAUD) @(posedge clk);
    rx = 1'b1;
    repeat (BAUD / 2) @(posedge clk);
    #1;
    check("rst busy before", busy, 1);
    #2;
    reset_n = 1'b0;
    prog = 1'b0;
    #1;
    check("rst outputs immediate", {wr_en, wr_addr, wr_data, busy, done, error}, 0);
    repeat (5) @(posedge clk);
    reset_n = 1'b1;
    wq.delete();
    repeat (30 * BAUD) @(posedge clk);
    #1;
    check("rst no writes after", wq.size(), 0);
    check("rst busy after", busy, 0);

    // DATA_WIDTH = 2: E4 -> 3,2,1,0 ; checksum 00+01+E4 = E5
    wq2.delete();
    start_frame(1);
    send_byte(1, 8'h00); send_byte(1, 8'h01); send_byte(1, 8'hE4); send_byte(1, 8'hE5);
    repeat (2 * BAUD) @(posedge clk);
    #1;
    check("dw2 wr_count", wq2.size(), 4);
    for (int j = 0; j < 4; j++)
      if (j < wq2.size()) check($sformatf("dw2 wr%0d", j), wq2[j], {4'(j), 2'(3 - j)});
    check("dw2 done", done2, 1);
    check("dw2 error", error2, 0);
    check("dw2 busy", busy2, 0);
    // capacity with 2-bit words is 4 bytes
    wq2.delete();
    start_frame(1);
    send_byte(1, 8'h00); send_byte(1, 8'h05);
    repeat (2 * BAUD) @(posedge clk);
    #1;
    check("dw2 len5 error", error2, 1);
    check("dw2 len5 done", done2, 0);
    check("dw2 len5 wr_count", wq2.size(), 0);

    check("done_error_exclusive", both_hi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
